// File: rtl/mpsoc_apb_gpio_arbiter.sv
// mpsoc_apb_gpio_arbiter: shares one APB master port toward a GPIO slave among NREQ requesters.
// Grants are round-robin. Each transfer walks IDLE -> SETUP -> ACCESS -> COMPLETE and returns
// a one-cycle done pulse with the captured read data and error flag.
// Optional feature: define MPSOC_APB_GPIO_ARB_TIMEOUT_EN to add an ACCESS-phase watchdog that
// ends a stalled transfer after TIMEOUT wait cycles with an error.
module mpsoc_apb_gpio_arbiter #(
  parameter int unsigned PADDR_SIZE = 64,
  parameter int unsigned PDATA_SIZE = 64,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              req_we_i,
  input  logic [NREQ-1:0]              req_strb_i,
  input  logic [NREQ*PADDR_SIZE-1:0]   req_addr_i,
  input  logic [NREQ*PDATA_SIZE-1:0]   req_wdata_i,
  output logic [NREQ-1:0]              req_done_o,
  output logic [PDATA_SIZE-1:0]        req_rdata_o,
  output logic                         req_err_o,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic                         PSTRB,
  output logic [PADDR_SIZE-1:0]        PADDR,
  output logic [PDATA_SIZE-1:0]        PWDATA,
  input  logic [PDATA_SIZE-1:0]        PRDATA,
  input  logic                         PREADY,
  input  logic                         PSLVERR
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StComplete} state_e;

  state_e          state_q;
  logic [IdxW-1:0] last_grant_q;
  logic [IdxW-1:0] win_q;

`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
`endif

  logic [PADDR_SIZE-1:0] addr_arr  [NREQ];
  logic [PDATA_SIZE-1:0] wdata_arr [NREQ];
  logic                  pick_valid;
  logic [IdxW-1:0]       pick_idx;
  logic [IdxW-1:0]       cand;

  // Split the flat per-requester buses into indexable slices.
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr_i[k*PADDR_SIZE +: PADDR_SIZE];
    assign wdata_arr[k] = req_wdata_i[k*PDATA_SIZE +: PDATA_SIZE];
  end

  // Round-robin pick: scan from last_grant+1 and take the first active request.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(last_grant_q) + i) % NREQ);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Transfer FSM with all APB and requester outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NREQ - 1);
      win_q        <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PSTRB        <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      req_done_o   <= '0;
      req_rdata_o  <= '0;
      req_err_o    <= 1'b0;
`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      req_done_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            win_q   <= pick_idx;
            PWRITE  <= req_we_i[pick_idx];
            PSTRB   <= req_strb_i[pick_idx];
            PADDR   <= addr_arr[pick_idx];
            PWDATA  <= wdata_arr[pick_idx];
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          PENABLE <= 1'b1;
          state_q <= StAccess;
`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StAccess: begin
          if (PREADY) begin
            req_rdata_o  <= PRDATA;
            req_err_o    <= PSLVERR;
            req_done_o   <= NREQ'(1) << win_q;
            last_grant_q <= win_q;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state_q      <= StComplete;
          end
`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
          // Watchdog: the slave stalled for TIMEOUT cycles, end the transfer as an error.
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            req_rdata_o  <= '0;
            req_err_o    <= 1'b1;
            req_done_o   <= NREQ'(1) << win_q;
            last_grant_q <= win_q;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state_q      <= StComplete;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StComplete: begin
          // req_i is deliberately not sampled here; requesters get one cycle to drop it.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_apb_gpio_arbiter.sv
// Bench for mpsoc_apb_gpio_arbiter: directed transfers, a protocol-level reference model checked
// every cycle, and literal expectations for latency, grant order, errors and reset abort.
module tb_mpsoc_apb_gpio_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [3:0]    req_i, req_we_i, req_strb_i;
  logic [255:0]  req_addr_i, req_wdata_i;
  logic [3:0]    req_done_o;
  logic [63:0]   req_rdata_o;
  logic          req_err_o;
  logic          PSEL, PENABLE, PWRITE, PSTRB;
  logic [63:0]   PADDR, PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  logic [63:0]   b_addr  [4];
  logic [63:0]   b_wdata [4];

  assign req_addr_i  = {b_addr[3], b_addr[2], b_addr[1], b_addr[0]};
  assign req_wdata_i = {b_wdata[3], b_wdata[2], b_wdata[1], b_wdata[0]};

  mpsoc_apb_gpio_arbiter #(
    .PADDR_SIZE(64), .PDATA_SIZE(64), .NREQ(NR), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_i(req_i), .req_we_i(req_we_i), .req_strb_i(req_strb_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_done_o(req_done_o), .req_rdata_o(req_rdata_o), .req_err_o(req_err_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: stall for slave_wait ACCESS cycles, then answer.
  int          slave_wait = 0;
  int          acc_cnt    = 0;
  logic [63:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PRDATA  <= slave_rdata;
      PSLVERR <= slave_err;
      if (acc_cnt < slave_wait) begin
        PREADY  <= 1'b0;
        acc_cnt <= acc_cnt + 1;
      end else begin
        PREADY <= 1'b1;
      end
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      acc_cnt <= 0;
    end
  end

  // Reference model: one APB transfer per grant, phases idle/setup/access/complete.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return 0;
  endfunction

  int          m_phase = 0;  // 0 idle, 1 setup, 2 access, 3 complete
  int          m_last  = 3;
  int          m_win   = 0;
  int          m_wait  = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_we = 1'b0, m_strb = 1'b0, m_err = 1'b0;
  logic [3:0]  m_done = '0;

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_valid <= 1'b1;
      m_phase <= 0;
      m_last  <= 3;
      m_addr  <= '0;
      m_wdata <= '0;
      m_we    <= 1'b0;
      m_strb  <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      m_done  <= '0;
    end else begin
      m_done <= '0;
      case (m_phase)
        0: if (req_i != 4'b0) begin
          m_win   <= rr_pick(req_i, m_last);
          m_addr  <= b_addr[rr_pick(req_i, m_last)];
          m_wdata <= b_wdata[rr_pick(req_i, m_last)];
          m_we    <= req_we_i[rr_pick(req_i, m_last)];
          m_strb  <= req_strb_i[rr_pick(req_i, m_last)];
          m_phase <= 1;
        end
        1: begin
          m_phase <= 2;
          m_wait  <= 0;
        end
        2: if (PREADY) begin
          m_rdata <= PRDATA;
          m_err   <= PSLVERR;
          m_done  <= 4'(1 << m_win);
          m_last  <= m_win;
          m_phase <= 3;
        end else begin
`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
          if (m_wait + 1 >= TO) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
            m_done  <= 4'(1 << m_win);
            m_last  <= m_win;
            m_phase <= 3;
          end else begin
            m_wait <= m_wait + 1;
          end
`else
          m_wait <= m_wait + 1;
`endif
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge PCLK) begin
    if (m_valid) begin
      chk("psel",   PSEL,        (m_phase == 1 || m_phase == 2));
      chk("penable", PENABLE,    (m_phase == 2));
      chk("done",   req_done_o,  m_done);
      chk("paddr",  PADDR,       m_addr);
      chk("pwdata", PWDATA,      m_wdata);
      chk("pwrite", PWRITE,      m_we);
      chk("pstrb",  PSTRB,       m_strb);
      chk("rdata",  req_rdata_o, m_rdata);
      chk("err",    req_err_o,   m_err);
    end
  end

  // One transfer by requester k; returns cycles to done, ACCESS cycles and observed results.
  task automatic xfer(input int k, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                      input int nwait, input logic [63:0] rd, input logic se,
                      output int lat, output int acc, output logic [3:0] dn,
                      output logic [63:0] ro, output logic eo,
                      output logic [63:0] pa, output logic [63:0] pw);
    slave_wait    = nwait;
    slave_rdata   = rd;
    slave_err     = se;
    req_we_i[k]   = we;
    req_strb_i[k] = 1'b1;
    b_addr[k]     = addr;
    b_wdata[k]    = wd;
    req_i[k]      = 1'b1;
    lat = 0; acc = 0; dn = '0; ro = '0; eo = 1'b0; pa = '0; pw = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge PCLK);
      lat++;
      if (PSEL && PENABLE) begin
        acc++;
        pa = PADDR;
        pw = PWDATA;
      end
      if (req_done_o != 4'b0) begin
        dn = req_done_o;
        ro = req_rdata_o;
        eo = req_err_o;
        break;
      end
    end
    req_i[k] = 1'b0;
  endtask

  // Hold the masked requesters high for n grants, logging the granted index of each done.
  int rr_log [8];

  task automatic run_rr(input logic [3:0] mask, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) rr_log[i] = -1;
    slave_wait = 0;
    slave_err  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_addr[i]  = 64'h100 + 64'(i);
      b_wdata[i] = 64'hC0 + 64'(i);
    end
    req_i = mask;
    for (int c = 0; c < 400 && cnt < n; c++) begin
      @(negedge PCLK);
      if (req_done_o != 4'b0) begin
        for (int b = 0; b < 4; b++) if (req_done_o[b]) rr_log[cnt] = b;
        cnt++;
      end
    end
    req_i = '0;
  endtask

  int          lat, acc;
  logic [3:0]  dn;
  logic [63:0] ro, pa, pw;
  logic        eo;
  int          exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  bit          seen, any_done;

  initial begin
    PRESET = 1'b1;
    req_i = '0; req_we_i = '0; req_strb_i = '0;
    for (int i = 0; i < 4; i++) begin
      b_addr[i]  = '0;
      b_wdata[i] = '0;
    end
    repeat (3) @(negedge PCLK);
    chk("rst_psel",    PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr",   PADDR, 64'h0);
    chk("rst_pwdata",  PWDATA, 64'h0);
    chk("rst_done",    req_done_o, 4'b0);
    chk("rst_rdata",   req_rdata_o, 64'h0);
    chk("rst_err",     req_err_o, 1'b0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Single write from requester 0.
    xfer(0, 1'b1, 64'h2, 64'hA5, 0, 64'h0, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_access",  64'(acc), 64'd1);
    chk("wr_done",    dn, 4'b0001);
    chk("wr_err",     eo, 1'b0);
    chk("wr_paddr",   pa, 64'h2);
    chk("wr_pwdata",  pw, 64'hA5);

    // Read from requester 2 with three wait states.
    xfer(2, 1'b0, 64'h3, 64'h0, 3, 64'h5A, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("rd_access", 64'(acc), 64'd4);
    chk("rd_done",   dn, 4'b0100);
    chk("rd_rdata",  ro, 64'h5A);
    chk("rd_paddr",  pa, 64'h3);

    // Slave error, then a clean transfer clears the flag.
    xfer(1, 1'b1, 64'h10, 64'h77, 0, 64'h0, 1'b1, lat, acc, dn, ro, eo, pa, pw);
    chk("slverr_err",  eo, 1'b1);
    chk("slverr_done", dn, 4'b0010);
    xfer(1, 1'b0, 64'h10, 64'h0, 1, 64'h33, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("clean_err",   eo, 1'b0);
    chk("clean_rdata", ro, 64'h33);

    // Round-robin from reset with all four requesters held high.
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    run_rr(4'hF, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_grant%0d", i), 64'(rr_log[i]), 64'(exp_rr[i]));

    // Reset during ACCESS: leave last grant at 1, start requester 2, abort it.
    xfer(1, 1'b0, 64'h20, 64'h0, 0, 64'h11, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("pre_abort_done", dn, 4'b0010);
    slave_wait = 50;
    b_addr[2]  = 64'h44;
    req_i[2]   = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) seen = 1'b1;
    end
    chk("abort_reached_access", seen, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("abort_psel", PSEL, 1'b0);
    chk("abort_done", req_done_o, 4'b0);
    PRESET = 1'b0;
    req_i = '0;
    slave_wait = 0;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (req_done_o != 4'b0) any_done = 1'b1;
    end
    chk("abort_no_done", any_done, 1'b0);
    run_rr(4'b0101, 1);
    chk("abort_next_grant", 64'(rr_log[0]), 64'd0);

    // ACCESS watchdog, or indefinite wait when the watchdog is not built.
`ifdef MPSOC_APB_GPIO_ARB_TIMEOUT_EN
    xfer(0, 1'b0, 64'h4, 64'h0, 1000, 64'hFF, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("to_access", 64'(acc), 64'd16);
    chk("to_done",   dn, 4'b0001);
    chk("to_err",    eo, 1'b1);
    chk("to_rdata",  ro, 64'h0);
`else
    xfer(0, 1'b0, 64'h4, 64'h0, 30, 64'hFF, 1'b0, lat, acc, dn, ro, eo, pa, pw);
    chk("nto_access", 64'(acc), 64'd31);
    chk("nto_done",   dn, 4'b0001);
    chk("nto_err",    eo, 1'b0);
    chk("nto_rdata",  ro, 64'hFF);
`endif

    repeat (3) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpsoc_apb_gpio_arbiter.md
MPSOC_APB_GPIO_ARBITER -- requirements
Module: mpsoc_apb_gpio_arbiter

Interface
REQ-001 Parameters SHALL be: PADDR_SIZE, default 64, APB address width; PDATA_SIZE, default 64, APB data width; NREQ, default 4, number of requesters (2..8); TIMEOUT, default 16, watchdog limit in cycles.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-003 PCLK  in  1  clock; all state changes on the rising edge.
REQ-004 PRESET  in  1  reset; synchronous, active-high.
REQ-005 req_i  in  NREQ  per-requester request; held high until done.
REQ-006 req_we_i  in  NREQ  per-requester write (1) or read (0).
REQ-007 req_strb_i  in  NREQ  per-requester byte-0 strobe.
REQ-008 req_addr_i  in  NREQ*PADDR_SIZE  per-requester address; slice k = bits [k*PADDR_SIZE +: PADDR_SIZE].
REQ-009 req_wdata_i  in  NREQ*PDATA_SIZE  per-requester write data; sliced the same way.
REQ-010 req_done_o  out  NREQ  one-cycle completion pulse to the owning requester.
REQ-011 req_rdata_o  out  PDATA_SIZE  read data shared by all requesters; valid while done is high.
REQ-012 req_err_o  out  1  error flag; valid while done is high.
REQ-013 PSEL, PENABLE, PWRITE, PSTRB  out  1 each  APB master controls toward the GPIO slave.
REQ-014 PADDR  out  PADDR_SIZE  APB master address; PWDATA  out  PDATA_SIZE  APB master write data.
REQ-015 PRDATA  in  PDATA_SIZE; PREADY  in  1; PSLVERR  in  1  APB slave responses.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, ACCESS and COMPLETE.
REQ-017 IDLE: if any req_i bit is high, the block SHALL latch the winner index and its we/strb/addr/wdata, then go to SETUP; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ, and the first high req_i found wins.
REQ-019 SETUP: PSEL=1, PENABLE=0, and PADDR/PWRITE/PSTRB/PWDATA SHALL be driven from the latched values; the next state is unconditionally ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; the block SHALL hold in ACCESS while PREADY=0; when PREADY=1 it SHALL capture PRDATA into req_rdata_o and PSLVERR into req_err_o, then go to COMPLETE.
REQ-021 COMPLETE: req_done_o[winner]=1 for exactly this cycle, PSEL=0, PENABLE=0; last_grant SHALL be set to the winner; the next state is IDLE.
REQ-022 Minimum transfer time: req_i sampled in IDLE at edge t gives SETUP in t..t+1, ACCESS in t+1..t+2 and done in t+2..t+3, i.e. 4 cycles from IDLE back to IDLE.
REQ-023 A requester SHALL deassert req_i in the cycle after its done pulse, or issue a new transfer by keeping req_i high; the arbiter SHALL NOT sample req_i during COMPLETE.
REQ-024 Latched command fields SHALL stay stable from SETUP through ACCESS regardless of req_* input changes.
REQ-025 req_rdata_o SHALL hold its last captured value between transfers; for writes it SHALL still capture PRDATA.
REQ-026 Outside SETUP and ACCESS, PSEL and PENABLE SHALL be 0; PADDR, PWDATA, PWRITE and PSTRB SHALL hold their last values.
REQ-027 If only one requester is active, it SHALL be granted on every IDLE visit, with no starvation of other requesters.
REQ-028 A req_i bit dropped before its grant SHALL be ignored; dropping req_i after grant SHALL NOT abort the transfer.

Reset
REQ-029 With PRESET=1 at an edge: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, PADDR=0, PWDATA=0, req_done_o=0, req_rdata_o=0, req_err_o=0, last_grant=NREQ-1 (so requester 0 has priority first).
REQ-030 Reset asserted during SETUP, ACCESS or COMPLETE SHALL abort the transfer with no done pulse; PSEL SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-031 Macro MPSOC_APB_GPIO_ARB_TIMEOUT_EN defined: a counter, cleared on SETUP, SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT the block SHALL go to COMPLETE with req_err_o=1 and req_rdata_o=0.
REQ-032 Macro MPSOC_APB_GPIO_ARB_TIMEOUT_EN undefined: no counter SHALL exist, ACCESS SHALL wait indefinitely for PREADY, and TIMEOUT SHALL be unused.

Verification
REQ-033 Single write: req_i=0001, we=1, strb=1, addr=0x2, wdata=0xA5, PREADY=1 -> SETUP at cycle 1, ACCESS at cycle 2 with PADDR=0x2/PWDATA=0xA5, req_done_o=0001 at cycle 3, req_err_o=0.
REQ-034 Read with 3 wait states: req_i=0100, addr=0x3, PREADY low for 3 ACCESS cycles, PRDATA=0x5A -> ACCESS lasts 4 cycles, req_done_o=0100, req_rdata_o=0x5A.
REQ-035 Round-robin: all four req_i held high for 8 transfers from reset -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Slave error: PSLVERR=1 with PREADY=1 -> req_err_o=1 with the done pulse; req_err_o=0 on the next clean transfer.
REQ-037 Reset during ACCESS: PRESET pulsed while PENABLE=1 -> PSEL=0 the next cycle, no done pulse, requester 0 has priority next.
REQ-038 Timeout, macro defined with TIMEOUT=16, PREADY held 0 -> done after 16 ACCESS cycles with req_err_o=1; macro undefined -> no done until PREADY=1.
